// File: rtl/avr_pkg.sv
// Shared types and constants for the AVR-style instruction fetch front end.
package avr_pkg;

  localparam int          PC_W_DEFAULT = 14;
  localparam logic [15:0] NOP_WORD     = 16'h0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding program-memory read, stall hold and redirect flush.
// Optional IFETCH_NOP_FLUSH_EN: a redirect presents one NOP to decode instead of a bubble.
module inst_fetch
  import avr_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic [15:0]     instR,
  output logic            inst_valid,
  output logic [PC_W-1:0] pc_out
);

  fetch_state_t    state_reg;
  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] stale_addr_reg;
  logic            consumed;
  logic            accept;

  // FETCH only asks for a new word when the current one can leave this cycle.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_reg;
    case (state_reg)
      FETCH:   imem_req = !inst_valid || !stall;
      FLUSH: begin
        imem_req  = 1'b1;
        imem_addr = stale_addr_reg;
      end
      default: imem_req = 1'b0;
    endcase
    if (rst) imem_req = 1'b0;
  end

  assign consumed = inst_valid && !stall;
  assign accept   = (state_reg == FETCH) && imem_req && imem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= FETCH;
      pc_reg         <= RESET_PC;
      stale_addr_reg <= RESET_PC;
      instR          <= NOP_WORD;
      pc_out         <= RESET_PC;
      inst_valid     <= 1'b0;
    end else if (redirect_valid) begin
      pc_reg <= redirect_pc;
      // A request still waiting for its ack must be completed (and dropped) first.
      if (imem_req && !imem_ack) begin
        state_reg      <= FLUSH;
        stale_addr_reg <= imem_addr;
      end else begin
        state_reg <= FETCH;
      end
`ifdef IFETCH_NOP_FLUSH_EN
      instR      <= NOP_WORD;
      inst_valid <= 1'b1;
`else
      inst_valid <= 1'b0;
`endif
    end else begin
      if (consumed) inst_valid <= 1'b0;
      case (state_reg)
        FETCH: begin
          if (accept) begin
            instR      <= imem_rdata;
            pc_out     <= pc_reg;
            inst_valid <= 1'b1;
            pc_reg     <= pc_reg + PC_W'(1);
          end else if (inst_valid && stall) begin
            state_reg <= HOLD;
          end
        end
        HOLD: begin
          if (!stall) state_reg <= FETCH;
        end
        FLUSH: begin
          if (imem_ack) state_reg <= FETCH;
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios then randomized traffic against a program-order model.
module tb_inst_fetch;
  import avr_pkg::*;

  localparam int PC_W = 14;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            stall = 1'b0;
  logic            redirect_valid = 1'b0;
  logic [PC_W-1:0] redirect_pc = '0;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_rdata;
  logic [15:0]     instR;
  logic            inst_valid;
  logic [PC_W-1:0] pc_out;

  int n_asserts = 0;
  int n_fail    = 0;

  // memory model: ack after the request has waited lat_now cycles
  int force_lat = 0;
  int rand_lat  = 0;
  int wcnt      = 0;
  int lat_now;

  // program-order model
  logic [PC_W-1:0] exp_pc = '0;
  bit              expect_nop = 1'b0;
  int              consumed_n = 0;
  bit              p_req = 1'b0, p_ack = 1'b0, p_hold = 1'b0, p_redir = 1'b0;
  logic [PC_W-1:0] p_addr = '0, p_pc_out = '0;
  logic [15:0]     p_instR = '0;

  inst_fetch #(.PC_W(PC_W), .RESET_PC(14'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instR(instR), .inst_valid(inst_valid), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [PC_W-1:0] a);
    if (a == 14'h0005) return 16'h0C01;
    return {2'b11, a};
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  always_comb lat_now = (force_lat >= 0) ? force_lat : rand_lat;
  assign imem_ack = imem_req && (wcnt >= lat_now);

  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (!imem_req || imem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  always @(posedge clk) begin
    if (imem_req && imem_ack) rand_lat <= $urandom_range(3, 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_cycle();
    if (p_req && !p_ack) begin
      chk("req_stable", 32'(imem_req), 32'd1);
      chk("addr_stable", 32'(imem_addr), 32'(p_addr));
    end
    if (p_hold) begin
      chk("hold_valid", 32'(inst_valid), 32'd1);
      chk("hold_instR", 32'(instR), 32'(p_instR));
      chk("hold_pc_out", 32'(pc_out), 32'(p_pc_out));
    end
    if (p_redir) begin
`ifdef IFETCH_NOP_FLUSH_EN
      chk("redir_nop_valid", 32'(inst_valid), 32'd1);
      chk("redir_nop_word", 32'(instR), 32'(NOP_WORD));
`else
      chk("redir_bubble", 32'(inst_valid), 32'd0);
`endif
    end
    if (inst_valid && !stall && !redirect_valid) begin
      if (expect_nop) begin
        chk("nop_word", 32'(instR), 32'(NOP_WORD));
        expect_nop = 1'b0;
      end else begin
        chk("inst_word", 32'(instR), 32'(mem_word(exp_pc)));
        chk("inst_pc", 32'(pc_out), 32'(exp_pc));
        exp_pc = exp_pc + 14'd1;
      end
      consumed_n++;
    end
    if (redirect_valid) begin
      exp_pc = redirect_pc;
`ifdef IFETCH_NOP_FLUSH_EN
      expect_nop = 1'b1;
`endif
    end
    p_req    = imem_req;
    p_ack    = imem_ack;
    p_addr   = imem_addr;
    p_hold   = inst_valid && stall && !redirect_valid;
    p_instR  = instR;
    p_pc_out = pc_out;
    p_redir  = redirect_valid;
  endtask

  task automatic step(input bit s, input bit r, input logic [PC_W-1:0] rpc, input int fl);
    @(negedge clk);
    stall = s;
    redirect_valid = r;
    redirect_pc = rpc;
    force_lat = fl;
    #1;
    check_cycle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nc;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_instR", 32'(instR), 32'h0000);
    chk("rst_pc_out", 32'(pc_out), 32'h0000);
    rst = 1'b0;
    #1;
    check_cycle();
    chk("c0_addr", 32'(imem_addr), 32'd0);
    chk("c0_req", 32'(imem_req), 32'd1);
    chk("c0_valid", 32'(inst_valid), 32'd0);

    // zero-wait streaming
    for (int i = 1; i < 4; i++) begin
      step(1'b0, 1'b0, '0, 0);
      chk("zw_addr", 32'(imem_addr), 32'(i));
      chk("zw_valid", 32'(inst_valid), 32'd1);
      chk("zw_instR", 32'(instR), 32'(mem_word(14'(i - 1))));
    end

    // three-cycle ack delay on address 4
    step(1'b0, 1'b0, '0, 3);
    chk("dly_addr4", 32'(imem_addr), 32'd4);
    chk("dly_noack", 32'(imem_ack), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, '0, 3);
      chk("dly_addr_hold", 32'(imem_addr), 32'd4);
      chk("dly_valid0", 32'(inst_valid), 32'd0);
    end
    step(1'b0, 1'b0, '0, 3);
    chk("dly_ack", 32'(imem_ack), 32'd1);
    chk("dly_addr_ack", 32'(imem_addr), 32'd4);
    step(1'b0, 1'b0, '0, 0);
    chk("dly_instR", 32'(instR), 32'(mem_word(14'd4)));
    chk("dly_next_addr", 32'(imem_addr), 32'd5);

    // stall for four cycles holding 16'h0C01
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, '0, 0);
      chk("stl_instR", 32'(instR), 32'h0C01);
      chk("stl_pc_out", 32'(pc_out), 32'd5);
      chk("stl_req", 32'(imem_req), 32'd0);
    end
    step(1'b0, 1'b0, '0, 0);
    chk("stl_release_req", 32'(imem_req), 32'd0);
    step(1'b0, 1'b0, '0, 3);
    chk("stl_resume_req", 32'(imem_req), 32'd1);
    chk("stl_resume_addr", 32'(imem_addr), 32'd6);

    // redirect while the request for 6 is outstanding
    step(1'b0, 1'b1, 14'h0100, 3);
    chk("fl_noack", 32'(imem_ack), 32'd0);
    step(1'b0, 1'b0, '0, 3);
    chk("fl_stale_addr", 32'(imem_addr), 32'd6);
    chk("fl_req", 32'(imem_req), 32'd1);
    step(1'b0, 1'b0, '0, 3);
    chk("fl_stale_ack", 32'(imem_ack), 32'd1);
    chk("fl_no_valid", 32'(inst_valid), 32'd0);
    step(1'b0, 1'b0, '0, 0);
    chk("fl_target_addr", 32'(imem_addr), 32'h0100);
    chk("fl_target_valid", 32'(inst_valid), 32'd0);

    // redirect coinciding with an ack, toward the top of the address space
    step(1'b0, 1'b1, 14'h3FFE, 0);
    chk("ra_instR", 32'(instR), 32'(mem_word(14'h0100)));
    chk("ra_ack", 32'(imem_ack), 32'd1);
    step(1'b0, 1'b0, '0, 0);
    chk("ra_addr", 32'(imem_addr), 32'h3FFE);
    step(1'b0, 1'b0, '0, 0);
    chk("wrap_addr_3fff", 32'(imem_addr), 32'h3FFF);
    step(1'b0, 1'b0, '0, 0);
    chk("wrap_addr_0", 32'(imem_addr), 32'h0000);
    chk("wrap_instR", 32'(instR), 32'(mem_word(14'h3FFF)));
    chk("wrap_pc_out", 32'(pc_out), 32'h3FFF);

    // asynchronous reset in the middle of an outstanding request
    step(1'b0, 1'b0, '0, 5);
    step(1'b0, 1'b0, '0, 5);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_valid", 32'(inst_valid), 32'd0);
    chk("arst_instR", 32'(instR), 32'h0000);
    chk("arst_pc_out", 32'(pc_out), 32'h0000);
    @(negedge clk);
    rst = 1'b0;
    force_lat = -1;
    exp_pc = '0;
    expect_nop = 1'b0;
    p_req = 1'b0; p_ack = 1'b0; p_hold = 1'b0; p_redir = 1'b0;
    #1;
    check_cycle();
    chk("arst_restart_addr", 32'(imem_addr), 32'h0000);

    // randomized traffic
    nc = consumed_n;
    for (int i = 0; i < 3000; i++) begin
      logic [PC_W-1:0] rpc;
      rpc = ($urandom_range(1, 0) == 1) ? 14'(14'h3FFC + 14'($urandom_range(3, 0))) : 14'($urandom);
      step($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 5, rpc, -1);
    end
    chk("rand_progress", 32'((consumed_n - nc) > 200), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter PC_W, default 14, program-counter width in 16-bit words (16K-word flash).
REQ-002 SHALL have parameter RESET_PC, default 14'h0000, fetch address after reset.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port stall  input  1  decode stage cannot accept instR this cycle.
REQ-006 SHALL have port redirect_valid  input  1  branch/jump taken; restart fetch at redirect_pc.
REQ-007 SHALL have port redirect_pc  input  PC_W  new fetch address.
REQ-008 SHALL have port imem_req  output  1  program-memory read request.
REQ-009 SHALL have port imem_addr  output  PC_W  program-memory word address.
REQ-010 SHALL have port imem_ack  input  1  read complete; imem_rdata valid this cycle.
REQ-011 SHALL have port imem_rdata  input  16  instruction word.
REQ-012 SHALL have port instR  output  16  registered instruction to decode.
REQ-013 SHALL have port inst_valid  output  1  instR holds an unconsumed instruction.
REQ-014 SHALL have port pc_out  output  PC_W  address instR was fetched from.

Function
REQ-015 SHALL implement FSM states FETCH (imem_req=1, imem_addr=pc), HOLD (imem_req=0), FLUSH (imem_req=1, imem_addr=stale address).
REQ-016 SHALL hold imem_addr and imem_req stable from request until the ack cycle.
REQ-017 SHALL, on imem_ack in FETCH, load instR<=imem_rdata, pc_out<=imem_addr, inst_valid<=1, pc<=pc+1.
REQ-018 SHALL wrap pc from 2^PC_W-1 to 0 with no flag.
REQ-019 SHALL treat instR as consumed on any cycle with inst_valid=1 and stall=0.
REQ-020 SHALL sustain one instruction per cycle when imem_ack is asserted in the request cycle and stall=0.
REQ-021 SHALL, on ack in FETCH while inst_valid=1 and stall=1, refuse the ack (FETCH with req=0 equivalent): enter HOLD before requesting; i.e. FETCH issues imem_req only when inst_valid=0 or stall=0.
REQ-022 SHALL in HOLD keep instR, pc_out, inst_valid unchanged; return to FETCH on first cycle stall=0.
REQ-023 SHALL clear inst_valid after consumption when no new ack arrives in the same cycle.
REQ-024 SHALL give redirect_valid priority over stall and ack: pc<=redirect_pc, inst_valid<=0 (see REQ-030).
REQ-025 SHALL, on redirect while a request is outstanding without ack, enter FLUSH, discard the eventual ack data, then enter FETCH at redirect_pc.
REQ-026 SHALL, on redirect coinciding with ack, discard that data and enter FETCH at redirect_pc next cycle.
REQ-027 SHALL, on a second redirect during FLUSH, overwrite the target pc and stay in FLUSH.

Reset
REQ-028 SHALL on rst: state=FETCH, pc=RESET_PC, instR=16'h0000, pc_out=RESET_PC, inst_valid=0, imem_req=0 while rst high.
REQ-029 SHALL abandon any outstanding request on rst; memory is required to drop it too.

Configuration
REQ-030 SHALL with IFETCH_NOP_FLUSH_EN defined, on redirect drive instR=16'h0000 (NOP) with inst_valid=1 for one cycle instead of inst_valid=0; without it, inst_valid=0 and instR unchanged.

Structure
REQ-031 SHALL place FSM state enum, NOP_WORD constant (16'h0000) and PC_W default in shared package avr_pkg.
REQ-032 SHALL be a single module; no sub-module required.

Verification
REQ-033 Reset, zero-wait memory, stall=0 -> addresses 0,1,2,3 on consecutive cycles; instR tracks memory; inst_valid=1 from the second cycle.
REQ-034 Memory ack delayed 3 cycles -> imem_addr stable 3 cycles; inst_valid=0 until ack; pc increments once.
REQ-035 stall=1 for 4 cycles with instR=16'h0C01 -> instR, pc_out held, imem_req=0; resumes fetching pc+1 after release.
REQ-036 redirect_pc=14'h0100 during outstanding request -> FLUSH; stale data discarded; next imem_addr=14'h0100; no stale instR valid.
REQ-037 pc=14'h3FFF fetched -> next imem_addr=14'h0000.
REQ-038 With IFETCH_NOP_FLUSH_EN, redirect -> one cycle instR=16'h0000, inst_valid=1; without it, inst_valid=0 that cycle.
